// File: rtl/id_exe_stage.sv
// rtl/id_exe_stage.sv - ID/EXE pipeline register with skid buffer, load-use hazard stall and bubble counter
//
// Purpose: holds one decoded instruction (MAIN) toward EXE plus one overflow
// entry (SKID) so that the upstream ready never depends on out_ready_i.
// A load in MAIN whose destination matches an incoming source stalls ID.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   in_valid_i / in_ready_o      ID-side handshake
//   reg{1,2,3}_addr_i, reg{1,2,3}_i, alu_ctrl_i, src_mem_alu_i,
//   src_imm_reg_i, src_din_i, extension_i      incoming payload
//   flush_i                      drop every held entry
//   out_valid_o / out_ready_i    EXE-side handshake
//   *_o payload                  registered copy of the MAIN entry
//   hazard_o                     load-use hazard this cycle
//   bubble_cnt_o                 saturating count of stall bubbles

module id_exe_stage #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int ALUCTRL_W = 5,
  parameter int EXT_W     = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [ADDR_W-1:0]    reg1_addr_i,
  input  logic [ADDR_W-1:0]    reg2_addr_i,
  input  logic [ADDR_W-1:0]    reg3_addr_i,
  input  logic [DATA_W-1:0]    reg1_i,
  input  logic [DATA_W-1:0]    reg2_i,
  input  logic [DATA_W-1:0]    reg3_i,
  input  logic [ALUCTRL_W-1:0] alu_ctrl_i,
  input  logic                 src_mem_alu_i,
  input  logic                 src_imm_reg_i,
  input  logic                 src_din_i,
  input  logic [EXT_W-1:0]     extension_i,

  input  logic                 flush_i,

  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ADDR_W-1:0]    reg1_addr_o,
  output logic [ADDR_W-1:0]    reg2_addr_o,
  output logic [ADDR_W-1:0]    reg3_addr_o,
  output logic [DATA_W-1:0]    reg1_o,
  output logic [DATA_W-1:0]    reg2_o,
  output logic [DATA_W-1:0]    reg3_o,
  output logic [ALUCTRL_W-1:0] alu_ctrl_o,
  output logic                 src_mem_alu_o,
  output logic                 src_imm_reg_o,
  output logic                 src_din_o,
  output logic [EXT_W-1:0]     extension_o,

  output logic                 hazard_o,
  output logic [CNT_W-1:0]     bubble_cnt_o
);

  localparam int PAY_W = 3*ADDR_W + 3*DATA_W + ALUCTRL_W + 3 + EXT_W;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] main_pay;
  logic [PAY_W-1:0] skid_pay;
  logic             main_valid;
  logic             skid_valid;
  logic [CNT_W-1:0] bubble_cnt;
  logic             in_xfer;
  logic             out_xfer;

  assign in_pay = {reg1_addr_i, reg2_addr_i, reg3_addr_i,
                   reg1_i, reg2_i, reg3_i,
                   alu_ctrl_i, src_mem_alu_i, src_imm_reg_i, src_din_i,
                   extension_i};

  // Outputs are taken directly from the MAIN flops.
  assign {reg1_addr_o, reg2_addr_o, reg3_addr_o,
          reg1_o, reg2_o, reg3_o,
          alu_ctrl_o, src_mem_alu_o, src_imm_reg_o, src_din_o,
          extension_o} = main_pay;

  assign out_valid_o  = main_valid;
  assign bubble_cnt_o = bubble_cnt;

  // A load in MAIN writing a non-zero register that the incoming
  // instruction reads cannot be forwarded in time, so ID must wait.
  assign hazard_o = in_valid_i && main_valid && src_mem_alu_o &&
                    (reg3_addr_o != '0) &&
                    ((reg3_addr_o == reg1_addr_i) || (reg3_addr_o == reg2_addr_i));

  // Ready depends only on local state and ID-side inputs, never on out_ready_i.
  assign in_ready_o = !skid_valid && !hazard_o && !flush_i;

  assign in_xfer  = in_valid_i && in_ready_o;
  assign out_xfer = main_valid && out_ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_pay   <= '0;
      skid_pay   <= '0;
    end else if (flush_i) begin
      // Payload is left stale; only the valid bits matter.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_xfer) begin
      if (skid_valid) begin
        // in_xfer is impossible here because SKID is occupied.
        main_pay   <= skid_pay;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        main_pay   <= in_pay;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      if (!main_valid) begin
        main_pay   <= in_pay;
        main_valid <= 1'b1;
      end else begin
        skid_pay   <= in_pay;
        skid_valid <= 1'b1;
      end
    end
  end

  // A hazard cycle with EXE ready is a slot EXE received no new work for.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if (hazard_o && out_ready_i && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_exe_stage.sv
// tb/tb_id_exe_stage.sv - randomized and directed check of id_exe_stage against a queue model

module tb_id_exe_stage;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0]  r1a;
    logic [4:0]  r2a;
    logic [4:0]  r3a;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] r3;
    logic [4:0]  alu;
    logic        mem;
    logic        imm;
    logic        din;
    logic [1:0]  ext;
  } pay_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic flush = 1'b0;
  pay_t cur = '0;

  logic             in_ready_o, out_valid_o, hazard_o;
  logic [CNT_W-1:0] bubble_cnt_o;
  logic [4:0]       r1a_o, r2a_o, r3a_o, alu_o;
  logic [31:0]      r1_o, r2_o, r3_o;
  logic             mem_o, imm_o, din_o;
  logic [1:0]       ext_o;
  pay_t             obs;

  assign obs = {r1a_o, r2a_o, r3a_o, r1_o, r2_o, r3_o, alu_o, mem_o, imm_o, din_o, ext_o};

  always #5 clk = ~clk;

  id_exe_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .reg1_addr_i(cur.r1a), .reg2_addr_i(cur.r2a), .reg3_addr_i(cur.r3a),
    .reg1_i(cur.r1), .reg2_i(cur.r2), .reg3_i(cur.r3),
    .alu_ctrl_i(cur.alu), .src_mem_alu_i(cur.mem), .src_imm_reg_i(cur.imm),
    .src_din_i(cur.din), .extension_i(cur.ext),
    .flush_i(flush),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready),
    .reg1_addr_o(r1a_o), .reg2_addr_o(r2a_o), .reg3_addr_o(r3a_o),
    .reg1_o(r1_o), .reg2_o(r2_o), .reg3_o(r3_o),
    .alu_ctrl_o(alu_o), .src_mem_alu_o(mem_o), .src_imm_reg_o(imm_o),
    .src_din_o(din_o), .extension_o(ext_o),
    .hazard_o(hazard_o), .bubble_cnt_o(bubble_cnt_o)
  );

  int   errors = 0;
  int   checks = 0;
  pay_t q[$];
  int   mcnt = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic pay_t mk(input logic [4:0] r1a, input logic [4:0] r2a,
                              input logic [4:0] r3a, input logic mem);
    pay_t p;
    p.r1a = r1a; p.r2a = r2a; p.r3a = r3a;
    p.r1 = $urandom; p.r2 = $urandom; p.r3 = $urandom;
    p.alu = 5'($urandom); p.mem = mem;
    p.imm = 1'($urandom); p.din = 1'($urandom); p.ext = 2'($urandom);
    return p;
  endfunction

  task automatic drive(input logic v, input pay_t p, input logic ordy, input logic fl);
    in_valid = v; cur = p; out_ready = ordy; flush = fl;
  endtask

  // Inputs are set just after a falling edge; check, then predict the rising edge.
  task automatic cycle(input string tag);
    bit hz, ir, ixf, oxf;
    #1;
    hz = in_valid && (q.size() > 0) && q[0].mem && (q[0].r3a != 0) &&
         ((q[0].r3a == cur.r1a) || (q[0].r3a == cur.r2a));
    ir = (q.size() < 2) && !hz && !flush;
    check({tag, ".out_valid"}, out_valid_o, q.size() > 0);
    check({tag, ".in_ready"}, in_ready_o, ir);
    check({tag, ".hazard"}, hazard_o, hz);
    check({tag, ".bubble"}, bubble_cnt_o, mcnt);
    if (q.size() > 0) check({tag, ".payload"}, obs, q[0]);
    ixf = in_valid && ir;
    oxf = (q.size() > 0) && out_ready;
    if (hz && out_ready && mcnt < MAXC) mcnt++;
    if (flush) q.delete();
    else begin
      if (oxf) void'(q.pop_front());
      if (ixf) q.push_back(cur);
    end
    @(negedge clk);
  endtask

  task automatic fill_two(input string tag);
    drive(1, mk(1, 2, 3, 0), 0, 0); cycle({tag, ".f0"});
    drive(1, mk(1, 2, 4, 0), 0, 0); cycle({tag, ".f1"});
    drive(0, '0, 0, 0);             cycle({tag, ".f2"});
  endtask

  initial begin
    // Reset state, asserted before any clock edge.
    #2;
    check("rst.out_valid", out_valid_o, 0);
    check("rst.payload", obs, 0);
    check("rst.bubble", bubble_cnt_o, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    drive(0, '0, 0, 0); cycle("rel");

    // Back-to-back stream, one-cycle latency.
    drive(1, mk(1, 2, 3, 0), 1, 0); cycle("s.A");
    drive(1, mk(4, 5, 6, 0), 1, 0); cycle("s.B");
    drive(1, mk(7, 8, 9, 0), 1, 0); cycle("s.C");
    drive(0, '0, 1, 0);             cycle("s.d0");
    drive(0, '0, 1, 0);             cycle("s.d1");

    // Backpressure into SKID and release.
    drive(1, mk(1, 2, 3, 0), 0, 0); cycle("k.A");
    drive(1, mk(4, 5, 6, 0), 0, 0); cycle("k.B");
    drive(1, mk(7, 8, 9, 0), 0, 0); cycle("k.hold");
    drive(0, '0, 1, 0);             cycle("k.outA");
    drive(0, '0, 1, 0);             cycle("k.outB");
    drive(0, '0, 1, 0);             cycle("k.empty");

    // Load-use hazard, then the same with destination r0.
    drive(1, mk(1, 2, 5, 1), 0, 0); cycle("h.ld");
    drive(1, mk(9, 5, 7, 0), 0, 0); cycle("h.use");
    check("h.hazard_seen", mcnt, 0);
    drive(0, '0, 1, 0);             cycle("h.drain0");
    drive(0, '0, 1, 0);             cycle("h.drain1");
    drive(1, mk(1, 2, 0, 1), 0, 0); cycle("z.ld");
    drive(1, mk(0, 0, 7, 0), 0, 0); cycle("z.use");
    drive(0, '0, 1, 0);             cycle("z.drain0");
    drive(0, '0, 1, 0);             cycle("z.drain1");
    drive(0, '0, 1, 0);             cycle("z.drain2");

    // Five bubble cycles, counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      drive(1, mk(1, 2, 6, 1), 1, 0); cycle($sformatf("b%0d.ld", i));
      drive(1, mk(6, 1, 2, 0), 1, 0); cycle($sformatf("b%0d.bub", i));
      drive(0, '0, 1, 0);             cycle($sformatf("b%0d.idle", i));
    end
    check("b.saturated", bubble_cnt_o, 3);

    // Flush with both entries full and input offered.
    fill_two("fl");
    drive(1, mk(1, 2, 3, 0), 1, 1); cycle("fl.flush");
    drive(0, '0, 1, 0);             cycle("fl.after0");
    drive(0, '0, 1, 0);             cycle("fl.after1");
    check("fl.bubble_kept", bubble_cnt_o, 3);

    // Asynchronous reset mid-cycle with both entries full.
    fill_two("ar");
    #3 rst = 1'b0;
    #1;
    check("ar.out_valid", out_valid_o, 0);
    check("ar.payload", obs, 0);
    check("ar.bubble", bubble_cnt_o, 0);
    q.delete(); mcnt = 0;
    @(negedge clk);
    rst = 1'b1;
    drive(0, '0, 1, 0); cycle("ar.rel");
    drive(0, '0, 1, 0); cycle("ar.empty");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      pay_t p;
      p = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom));
      drive(($urandom % 10) < 7, p, ($urandom % 10) < 6, ($urandom % 20) == 0);
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_exe_stage.md
ID_EXE_STAGE -- requirements
Module: id_exe_stage

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register address width.
REQ-003 Parameter ALUCTRL_W, default 5, ALU control width; parameter EXT_W, default 2, extension select width; parameter CNT_W, default 16, bubble counter width.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid_i  input  1  ID payload valid; in_ready_o  output  1  stage can accept.
REQ-007 reg1_addr_i/reg2_addr_i/reg3_addr_i  input  ADDR_W each  source 1, source 2, destination addresses.
REQ-008 reg1_i/reg2_i/reg3_i  input  DATA_W each  operand data.
REQ-009 alu_ctrl_i  input  ALUCTRL_W; src_mem_alu_i, src_imm_reg_i, src_din_i  input  1 each; extension_i  input  EXT_W.
REQ-010 flush_i  input  1  kill all held entries (branch/exception).
REQ-011 out_valid_o  output  1; out_ready_i  input  1  EXE handshake.
REQ-012 Output payload mirrors REQ-007..009 with _o suffix, same widths.
REQ-013 hazard_o  output  1  load-use hazard detected this cycle.
REQ-014 bubble_cnt_o  output  CNT_W  saturating count of inserted bubbles.

Function
REQ-015 Payload = all REQ-007..009 fields; transfer in when in_valid_i && in_ready_o; transfer out when out_valid_o && out_ready_i.
REQ-016 Two entries: MAIN (drives outputs) and SKID; out_valid_o = MAIN valid; outputs come straight from MAIN flops, no combinational input-to-output path.
REQ-017 hazard_o = in_valid_i && MAIN valid && MAIN src_mem_alu && MAIN reg3_addr != 0 && (MAIN reg3_addr == reg1_addr_i || MAIN reg3_addr == reg2_addr_i).
REQ-018 in_ready_o = !SKID valid && !hazard_o && !flush_i.
REQ-019 Input transfer, MAIN empty or MAIN leaving this cycle with SKID empty: payload loads MAIN.
REQ-020 Input transfer, MAIN full and not leaving: payload loads SKID.
REQ-021 Output transfer with SKID full: SKID moves to MAIN, SKID cleared; in_ready_o stays low that cycle.
REQ-022 Order strictly FIFO; latency in->out is 1 cycle when out_ready_i high; no entry dropped or duplicated.
REQ-023 Cycle with hazard_o high and out_ready_i high: counts as one bubble; bubble_cnt_o increments by 1, saturating at 2^CNT_W-1.
REQ-024 flush_i high: MAIN and SKID valid cleared on next edge; input not accepted that cycle; flush overrides simultaneous input/output transfers; bubble_cnt_o unaffected.
REQ-025 Invalid entries retain stale payload; only valid bits are cleared by flush.
REQ-026 out_valid_o and payload stable while out_valid_o && !out_ready_i.

Reset
REQ-027 rst low: MAIN/SKID valid = 0, all payload outputs = 0, bubble_cnt_o = 0, immediately, independent of clk.
REQ-028 After rst release, in_ready_o = 1 in the first cycle (absent hazard/flush); reset mid-transfer discards both entries.

Verification
REQ-029 Stream A,B,C with out_ready_i=1 -> outputs A,B,C on consecutive cycles, 1-cycle latency, in_ready_o constant 1.
REQ-030 A accepted, out_ready_i=0, B offered -> B into SKID, in_ready_o=0; out_ready_i=1 -> A then B out, in_ready_o returns to 1 after B moves to MAIN.
REQ-031 MAIN = load with reg3_addr=5, out_ready_i=0, incoming reg2_addr_i=5 -> hazard_o=1, in_ready_o=0; same with reg3_addr=0 -> hazard_o=0.
REQ-032 Both entries full, flush_i=1 with in_valid_i=1 -> next cycle out_valid_o=0, nothing accepted, no stale entry emitted later.
REQ-033 CNT_W=2, 5 hazard bubble cycles with out_ready_i=1 -> bubble_cnt_o 1,2,3,3,3.
REQ-034 rst asserted mid-cycle with both entries full -> out_valid_o=0, payload 0, bubble_cnt_o=0 before next edge.
